// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-accumulate with signed/unsigned modes, guard bits and sticky overflow.
// Stage 1 registers the extended product, and stage 2 updates the accumulator. A stall freezes every register.
module mac_pipe #(
  parameter int W   = 16,
  parameter int G   = 8,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           in_valid,
  input  logic [2:0]     instruction,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   multiplicand,
  output logic [2*W-1:0] result,
  output logic [G-1:0]   protect,
  output logic           out_valid,
  output logic           overflow
);

  localparam int A = 2*W + G;

  typedef enum logic [2:0] {
    OP_CLR  = 3'b000,
    OP_MUL  = 3'b001,
    OP_MAC  = 3'b010,
    OP_MSB  = 3'b011,
    OP_NOP  = 3'b100,
    OP_UMUL = 3'b101,
    OP_UMAC = 3'b110,
    OP_UMSB = 3'b111
  } op_e;

  logic [2*W-1:0] a_ext, b_ext, prod;
  logic [A-1:0]   p_d;
  logic [A-1:0]   s1_p_q;
  op_e            s1_op_q;
  logic           s1_vld_q;
  logic [A-1:0]   acc_q, acc_d;
  logic           ovf_q, ovf_d;
  logic           out_vld_q;
  logic [A-1:0]   sum, diff;
  logic           add_ovf, sub_ovf;

  // Operand extension picks signed vs unsigned; the low 2W bits of the product are then exact.
  always_comb begin
    if (instruction[2]) begin
      a_ext = {{W{1'b0}}, multiplier};
      b_ext = {{W{1'b0}}, multiplicand};
    end else begin
      a_ext = {{W{multiplier[W-1]}}, multiplier};
      b_ext = {{W{multiplicand[W-1]}}, multiplicand};
    end
    prod = a_ext * b_ext;
    p_d  = instruction[2] ? {{G{1'b0}}, prod} : {{G{prod[2*W-1]}}, prod};
  end

  assign sum     = acc_q + s1_p_q;
  assign diff    = acc_q - s1_p_q;
  assign add_ovf = (acc_q[A-1] == s1_p_q[A-1]) && (sum[A-1]  != acc_q[A-1]);
  assign sub_ovf = (acc_q[A-1] != s1_p_q[A-1]) && (diff[A-1] != acc_q[A-1]);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    case (s1_op_q)
      OP_CLR: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      OP_MUL, OP_UMUL: acc_d = s1_p_q;
      OP_MAC, OP_UMAC, OP_MSB, OP_UMSB: begin
        acc_d = s1_op_q[0] ? diff : sum;
        if (s1_op_q[0] ? sub_ovf : add_ovf) begin
          ovf_d = 1'b1;
          // Direction of the overflow always follows the sign of the old accumulator.
          if (SAT != 0)
            acc_d = acc_q[A-1] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_p_q    <= '0;
      s1_op_q   <= OP_NOP;
      s1_vld_q  <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (!stall) begin
      s1_vld_q  <= in_valid;
      if (in_valid) begin
        s1_p_q  <= p_d;
        s1_op_q <= op_e'(instruction);
      end
      out_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign result    = acc_q[2*W-1:0];
  assign protect   = acc_q[A-1:2*W];
  assign out_valid = out_vld_q;
  assign overflow  = ovf_q;

endmodule
